// File: rtl/perf_counter_bank_pkg.sv
// Shared types and constants for the performance-counter bank.
// Optional build macro: PERF_CTR_SATURATE_EN (see perf_counter).
package perf_counter_bank_pkg;
  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } perf_state_t;

  localparam int PERF_CTRL_EN_BIT  = 0;
  localparam int PERF_CTRL_CLR_BIT = 1;
endpackage

// File: rtl/perf_counter_bank_if.sv
// Memory-port bus used on both the CPU side and the downstream side of the bank.
// Optional build macro: PERF_CTR_SATURATE_EN (no effect on this file).
interface perf_counter_bank_if;
  import perf_counter_bank_pkg::*;

  // Handshake: the master raises read or write with address/wdata and holds them
  // until the slave answers with a one-cycle resp; rdata is valid while resp=1.
  logic     read;
  logic     write;
  lc3b_word address;
  lc3b_word wdata;
  lc3b_word rdata;
  logic     resp;

  modport master (output read, write, address, wdata, input rdata, resp);
  modport slave  (input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/perf_counter_bank_ctr.sv
// Single event counter with clear, enable and overflow indication.
// PERF_CTR_SATURATE_EN: hold at all-ones instead of wrapping to zero.
module perf_counter
  import perf_counter_bank_pkg::*;
#(
  parameter int CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [CTR_WIDTH-1:0] o_count,
  output logic                 o_ovf
);
  logic [CTR_WIDTH-1:0] r_count;
  logic                 w_at_max;

  assign w_at_max = &r_count;
  // Clear wins over a same-cycle event, so no overflow is flagged then.
  assign o_ovf    = i_en && i_inc && w_at_max && !i_clr;
  assign o_count  = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && i_inc) begin
`ifdef PERF_CTR_SATURATE_EN
      if (!w_at_max) begin
        r_count <= r_count + CTR_WIDTH'(1);
      end
`else
      r_count <= r_count + CTR_WIDTH'(1);
`endif
    end
  end
endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped performance-counter bank spliced into the data-memory path.
// PERF_CTR_SATURATE_EN selects saturating counters (wrapping when undefined).
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int       NUM_CTRS  = 10,
  parameter int       CTR_WIDTH = 32,
  parameter lc3b_word BASE_ADDR = 16'hFFE0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CTRS-1:0]   i_events,
  perf_counter_bank_if.slave    cpu_bus,
  perf_counter_bank_if.master   mem_bus,
  output perf_state_t           o_dbg_state
);
  localparam logic [16:0] WIN_LAST = 17'(BASE_ADDR) + 17'(2 * NUM_CTRS);

  perf_state_t          r_state, w_next_state;
  logic                 r_en, r_ovf;
  lc3b_word             r_shadow, r_rdata;
  lc3b_word             w_off;
  logic                 w_in_win, w_req, w_rd, w_wr, w_is_ctrl, w_is_hi;
  logic                 w_clr_all, w_ctr_wr;
  logic [4:0]           w_idx;
  logic [NUM_CTRS-1:0]  w_clr, w_ovf;
  logic [CTR_WIDTH-1:0] w_count [NUM_CTRS];
  logic [31:0]          w_cnt32 [32];

  assign w_off     = cpu_bus.address - BASE_ADDR;
  assign w_in_win  = ({1'b0, cpu_bus.address} >= 17'(BASE_ADDR)) &&
                     ({1'b0, cpu_bus.address} <= WIN_LAST);
  assign w_is_ctrl = (w_off == 16'd0);
  assign w_is_hi   = ~w_off[0];
  assign w_idx     = 5'((w_off - 16'd1) >> 1);
  assign w_req     = (r_state == IDLE) && w_in_win && (cpu_bus.read || cpu_bus.write);
  assign w_rd      = w_req && cpu_bus.read;
  assign w_wr      = w_req && cpu_bus.write && !cpu_bus.read;
  assign w_clr_all = w_wr && w_is_ctrl && cpu_bus.wdata[PERF_CTRL_CLR_BIT];
  assign w_ctr_wr  = w_wr && !w_is_ctrl;

  for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
    assign w_clr[g] = w_clr_all || (w_ctr_wr && (w_idx == 5'(g)));
    perf_counter #(.CTR_WIDTH(CTR_WIDTH)) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (i_events[g]),
      .i_clr   (w_clr[g]),
      .i_en    (r_en),
      .o_count (w_count[g]),
      .o_ovf   (w_ovf[g])
    );
  end

  // Zero-extended 32-bit view, padded to 32 entries so any 5-bit index is legal.
  always_comb begin
    for (int i = 0; i < 32; i++) w_cnt32[i] = '0;
    for (int i = 0; i < NUM_CTRS; i++) w_cnt32[i] = 32'(w_count[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en     <= 1'b1;
      r_ovf    <= 1'b0;
      r_shadow <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_clr_all)  r_ovf <= 1'b0;
      else if (|w_ovf) r_ovf <= 1'b1;
      if (w_wr && w_is_ctrl) r_en <= cpu_bus.wdata[PERF_CTRL_EN_BIT];
      if (w_clr_all) r_shadow <= '0;
      if (w_rd) begin
        if (w_is_ctrl) begin
          r_rdata <= {14'd0, r_ovf, r_en};
        end else if (w_is_hi) begin
          r_rdata <= r_shadow;
        end else begin
          // Low-word read snapshots the upper half so a following high read is coherent.
          r_rdata  <= w_cnt32[w_idx][15:0];
          r_shadow <= w_cnt32[w_idx][31:16];
        end
      end else if (w_wr) begin
        r_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_bus.address = cpu_bus.address;
    mem_bus.wdata   = cpu_bus.wdata;
    mem_bus.read    = cpu_bus.read;
    mem_bus.write   = cpu_bus.write;
    cpu_bus.rdata   = mem_bus.rdata;
    cpu_bus.resp    = mem_bus.resp;
    if (w_in_win) begin
      mem_bus.read  = 1'b0;
      mem_bus.write = 1'b0;
      cpu_bus.rdata = r_rdata;
      cpu_bus.resp  = (r_state == RESP);
    end
  end

  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: main 10x32 instance plus a 2x8 instance
// for the overflow corner. Honors PERF_CTR_SATURATE_EN for expected values.
module tb_perf_counter_bank;
  import perf_counter_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  events;
  logic [1:0]  events8;
  perf_state_t dbg_state, dbg_state8;
  int          errors = 0;
  int          checks = 0;

`ifdef PERF_CTR_SATURATE_EN
  localparam lc3b_word EXP_MAX_PLUS1 = 16'h00FF;
  localparam lc3b_word EXP_MAX_PLUS2 = 16'h00FF;
`else
  localparam lc3b_word EXP_MAX_PLUS1 = 16'h0000;
  localparam lc3b_word EXP_MAX_PLUS2 = 16'h0001;
`endif

  perf_counter_bank_if cpu_if ();
  perf_counter_bank_if mem_if ();
  perf_counter_bank_if cpu8_if ();
  perf_counter_bank_if mem8_if ();

  always #5 clk = ~clk;

  perf_counter_bank dut (
    .clk         (clk),
    .rst         (rst),
    .i_events    (events),
    .cpu_bus     (cpu_if),
    .mem_bus     (mem_if),
    .o_dbg_state (dbg_state)
  );

  perf_counter_bank #(.NUM_CTRS(2), .CTR_WIDTH(8), .BASE_ADDR(16'hFFE0)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .i_events    (events8),
    .cpu_bus     (cpu8_if),
    .mem_bus     (mem8_if),
    .o_dbg_state (dbg_state8)
  );

  // Entered and left at posedge+1; request is held until resp or an 8-cycle bound.
  task automatic access(input bit sel, input bit rd, input bit wr, input lc3b_word addr,
                        input lc3b_word wd, output lc3b_word data, output int lat,
                        output bit leaked);
    data = '0; lat = -1; leaked = 1'b0;
    if (sel) begin
      cpu8_if.read = rd; cpu8_if.write = wr; cpu8_if.address = addr; cpu8_if.wdata = wd;
    end else begin
      cpu_if.read = rd; cpu_if.write = wr; cpu_if.address = addr; cpu_if.wdata = wd;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      leaked = leaked | (sel ? (mem8_if.read | mem8_if.write) : (mem_if.read | mem_if.write));
      if (sel ? cpu8_if.resp : cpu_if.resp) begin
        lat  = k;
        data = sel ? cpu8_if.rdata : cpu_if.rdata;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_if.read = 1'b0; cpu_if.write = 1'b0;
    cpu8_if.read = 1'b0; cpu8_if.write = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr=%h got=no_resp exp=resp", addr);
    end
  endtask

  task automatic pulse(input logic [9:0] mask, input int n);
    events = mask;
    repeat (n) @(posedge clk);
    #1 events = '0;
  endtask

  task automatic pulse8(input logic [1:0] mask, input int n);
    events8 = mask;
    repeat (n) @(posedge clk);
    #1 events8 = '0;
  endtask

  task automatic test_reset();
    lc3b_word d; int lat; bit lk;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
    checks++; if (cpu_if.resp !== 1'b0) begin errors++; $display("FAIL rst_resp got=%b exp=0", cpu_if.resp); end
    checks++; if (cpu_if.rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got=%h exp=0000", cpu_if.rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    access(0, 1, 0, 16'hFFE0, 16'h0, d, lat, lk);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ctrl_latency got=%0d exp=1", lat); end
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL ctrl_reset got=%h exp=0001", d); end
    checks++; if (lk !== 1'b0) begin errors++; $display("FAIL inwin_pass_strobe got=%b exp=0", lk); end
    access(0, 1, 0, 16'hFFE1, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ctr0_reset got=%h exp=0000", d); end
  endtask

  task automatic test_count_atomic();
    lc3b_word d; int lat; bit lk;
    pulse(10'b00_0000_0100, 70000);
    access(0, 1, 0, 16'hFFE5, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h1170) begin errors++; $display("FAIL cnt2_low got=%h exp=1170", d); end
    pulse(10'b00_0000_0100, 3);
    access(0, 1, 0, 16'hFFE6, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL cnt2_high_shadow got=%h exp=0001", d); end
    access(0, 1, 0, 16'hFFE5, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h1173) begin errors++; $display("FAIL cnt2_low_after got=%h exp=1173", d); end
  endtask

  task automatic test_enable();
    lc3b_word d; int lat; bit lk;
    access(0, 0, 1, 16'hFFE0, 16'h0000, d, lat, lk);
    pulse(10'h3FF, 5);
    access(0, 1, 0, 16'hFFE1, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL disabled_ctr0 got=%h exp=0000", d); end
    access(0, 1, 0, 16'hFFE5, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h1173) begin errors++; $display("FAIL disabled_ctr2 got=%h exp=1173", d); end
    access(0, 1, 0, 16'hFFE0, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ctrl_disabled got=%h exp=0000", d); end
    access(0, 0, 1, 16'hFFE0, 16'h0001, d, lat, lk);
    pulse(10'b00_0000_0001, 4);
    access(0, 1, 0, 16'hFFE1, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0004) begin errors++; $display("FAIL reenabled_ctr0 got=%h exp=0004", d); end
  endtask

  task automatic test_overflow();
    lc3b_word d; int lat; bit lk;
    pulse8(2'b01, 255);
    access(1, 1, 0, 16'hFFE1, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL ovf_at_max got=%h exp=00FF", d); end
    access(1, 1, 0, 16'hFFE0, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL ovf_ctrl_before got=%h exp=0001", d); end
    pulse8(2'b01, 1);
    access(1, 1, 0, 16'hFFE1, 16'h0, d, lat, lk);
    checks++; if (d !== EXP_MAX_PLUS1) begin errors++; $display("FAIL ovf_low got=%h exp=%h", d, EXP_MAX_PLUS1); end
    access(1, 1, 0, 16'hFFE2, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ovf_high got=%h exp=0000", d); end
    access(1, 1, 0, 16'hFFE0, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0003) begin errors++; $display("FAIL ovf_ctrl got=%h exp=0003", d); end
    pulse8(2'b01, 1);
    access(1, 1, 0, 16'hFFE1, 16'h0, d, lat, lk);
    checks++; if (d !== EXP_MAX_PLUS2) begin errors++; $display("FAIL ovf_next got=%h exp=%h", d, EXP_MAX_PLUS2); end
    access(1, 1, 0, 16'hFFE0, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0003) begin errors++; $display("FAIL ovf_sticky got=%h exp=0003", d); end
    access(1, 0, 1, 16'hFFE0, 16'h0003, d, lat, lk);
    access(1, 1, 0, 16'hFFE0, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL ovf_cleared got=%h exp=0001", d); end
    access(1, 1, 0, 16'hFFE1, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ovf_ctr_cleared got=%h exp=0000", d); end
  endtask

  task automatic test_clear();
    lc3b_word d; int lat; bit lk;
    pulse(10'b00_0000_0010, 6);
    access(0, 1, 0, 16'hFFE3, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0006) begin errors++; $display("FAIL ctr1_pre got=%h exp=0006", d); end
    // Counter write and event in the same cycle N only.
    events = 10'b00_0000_0010;
    cpu_if.write = 1'b1; cpu_if.address = 16'hFFE3; cpu_if.wdata = 16'h1234;
    @(posedge clk); #1 events = '0;
    @(negedge clk);
    checks++; if (cpu_if.resp !== 1'b1) begin errors++; $display("FAIL clr_write_resp got=%b exp=1", cpu_if.resp); end
    @(posedge clk); #1 cpu_if.write = 1'b0;
    access(0, 1, 0, 16'hFFE3, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL clr_wins got=%h exp=0000", d); end
    access(0, 1, 0, 16'hFFE1, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0004) begin errors++; $display("FAIL clr_other_kept got=%h exp=0004", d); end
    pulse(10'b00_0000_0010, 3);
    access(0, 0, 1, 16'hFFE4, 16'h0, d, lat, lk);
    access(0, 1, 0, 16'hFFE3, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL clr_via_high got=%h exp=0000", d); end
    access(0, 1, 0, 16'hFFE5, 16'h0, d, lat, lk);
    access(0, 0, 1, 16'hFFE0, 16'h0003, d, lat, lk);
    access(0, 1, 0, 16'hFFE6, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL clrall_shadow got=%h exp=0000", d); end
    access(0, 1, 0, 16'hFFE5, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL clrall_ctr2 got=%h exp=0000", d); end
    access(0, 1, 0, 16'hFFE0, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL clrall_ctrl got=%h exp=0001", d); end
  endtask

  task automatic test_passthrough();
    lc3b_word d; int lat; bit lk;
    mem_if.rdata = 16'hBEEF; mem_if.resp = 1'b0;
    cpu_if.read = 1'b1; cpu_if.address = 16'h1000; cpu_if.wdata = 16'h5A5A;
    #1;
    checks++; if (mem_if.read !== 1'b1) begin errors++; $display("FAIL pass_read got=%b exp=1", mem_if.read); end
    checks++; if (mem_if.address !== 16'h1000) begin errors++; $display("FAIL pass_addr got=%h exp=1000", mem_if.address); end
    checks++; if (cpu_if.rdata !== 16'hBEEF) begin errors++; $display("FAIL pass_rdata got=%h exp=BEEF", cpu_if.rdata); end
    checks++; if (cpu_if.resp !== 1'b0) begin errors++; $display("FAIL pass_resp0 got=%b exp=0", cpu_if.resp); end
    mem_if.resp = 1'b1; #1;
    checks++; if (cpu_if.resp !== 1'b1) begin errors++; $display("FAIL pass_resp1 got=%b exp=1", cpu_if.resp); end
    @(negedge clk);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL pass_fsm got=%0d exp=%0d", dbg_state, IDLE); end
    cpu_if.read = 1'b0; cpu_if.write = 1'b1; cpu_if.address = 16'hFFF5; #1;
    checks++; if (mem_if.write !== 1'b1 || mem_if.wdata !== 16'h5A5A) begin errors++; $display("FAIL pass_above_win got=%b/%h exp=1/5A5A", mem_if.write, mem_if.wdata); end
    cpu_if.write = 1'b0; cpu_if.read = 1'b1; cpu_if.address = 16'hFFDF; #1;
    checks++; if (mem_if.read !== 1'b1) begin errors++; $display("FAIL pass_below_win got=%b exp=1", mem_if.read); end
    mem_if.resp = 1'b0;
    @(posedge clk); #1 cpu_if.read = 1'b0;
    access(0, 1, 0, 16'hFFF4, 16'h0, d, lat, lk);
    checks++; if (lk !== 1'b0 || lat !== 1) begin errors++; $display("FAIL top_of_win got=%b/%0d exp=0/1", lk, lat); end
  endtask

  task automatic test_back_to_back();
    lc3b_word d; int lat; bit lk;
    logic [3:0] pat;
    access(0, 1, 1, 16'hFFE0, 16'h0000, d, lat, lk);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL rw_prio_data got=%h exp=0001", d); end
    access(0, 1, 0, 16'hFFE0, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL rw_prio_en_kept got=%h exp=0001", d); end
    cpu_if.read = 1'b1; cpu_if.address = 16'hFFE0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat[k] = cpu_if.resp;
    end
    @(posedge clk); #1 cpu_if.read = 1'b0;
    checks++; if (pat !== 4'b1010) begin errors++; $display("FAIL held_req_pattern got=%b exp=1010", pat); end
  endtask

  task automatic test_reset_in_resp();
    lc3b_word d; int lat; bit lk;
    pulse(10'b00_0000_0001, 2);
    cpu_if.read = 1'b1; cpu_if.address = 16'hFFE0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (cpu_if.resp !== 1'b1) begin errors++; $display("FAIL pre_rst_resp got=%b exp=1", cpu_if.resp); end
    #2 rst = 1'b1;
    #1;
    checks++; if (cpu_if.resp !== 1'b0) begin errors++; $display("FAIL rst_in_resp got=%b exp=0", cpu_if.resp); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_in_resp_fsm got=%0d exp=%0d", dbg_state, IDLE); end
    @(negedge clk);
    rst = 1'b0; cpu_if.read = 1'b0;
    @(posedge clk); #1;
    access(0, 1, 0, 16'hFFE0, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0001 || lat !== 1) begin errors++; $display("FAIL post_rst_ctrl got=%h/%0d exp=0001/1", d, lat); end
    access(0, 1, 0, 16'hFFE1, 16'h0, d, lat, lk);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL post_rst_ctr0 got=%h exp=0000", d); end
  endtask

  initial begin
    events = '0; events8 = '0;
    cpu_if.read = 1'b0; cpu_if.write = 1'b0; cpu_if.address = 16'hFFE0; cpu_if.wdata = '0;
    cpu8_if.read = 1'b0; cpu8_if.write = 1'b0; cpu8_if.address = 16'hFFE0; cpu8_if.wdata = '0;
    mem_if.rdata = '0; mem_if.resp = 1'b0;
    mem8_if.rdata = '0; mem8_if.resp = 1'b0;
    test_reset();
    test_count_atomic();
    test_enable();
    test_overflow();
    test_clear();
    test_passthrough();
    test_back_to_back();
    test_reset_in_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
